// File: rtl/uart_tx_engine.sv
// Serial UART transmitter: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
// Latency: a load sampled at clock edge k drives the start bit from k onward; the frame lasts bits*N clocks, then TXRDY rises with a one-clock tx_done.
// Backpressure: a load is taken only while TXRDY=1; loads that arrive while busy are dropped without queueing.
module uart_tx_engine #(
    parameter int CNT_W = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] baud,
    input  logic       eight,
    input  logic       parity,
    input  logic       OHEL,
    input  logic       load,
    input  logic [7:0] out_port,
    output logic       TX,
    output logic       TXRDY,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       baud_q, baud_d;
    logic             eight_q, eight_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             tx_q, tx_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] last_cnt;
    logic             bit_end;
    logic [2:0]       last_bit;
    logic [7:0]       data_mask;

    // Terminal count of the bit-time counter (N-1) for the baud captured at load.
    always_comb begin
        last_cnt = CNT_W'(867);
        case (baud_q)
            4'h0:    last_cnt = CNT_W'(333332);
            4'h1:    last_cnt = CNT_W'(83332);
            4'h2:    last_cnt = CNT_W'(41666);
            4'h3:    last_cnt = CNT_W'(20832);
            4'h4:    last_cnt = CNT_W'(10416);
            4'h5:    last_cnt = CNT_W'(5207);
            4'h6:    last_cnt = CNT_W'(2603);
            4'h7:    last_cnt = CNT_W'(1735);
            4'h8:    last_cnt = CNT_W'(867);
            4'h9:    last_cnt = CNT_W'(433);
            4'hA:    last_cnt = CNT_W'(216);
            4'hB:    last_cnt = CNT_W'(108);
            4'hC:    last_cnt = CNT_W'(54);
            4'hD:    last_cnt = CNT_W'(27);
            default: last_cnt = CNT_W'(867);
        endcase
    end

    assign bit_end   = (cnt_q == last_cnt);
    assign last_bit  = eight_q ? 3'd7 : 3'd6;
    assign data_mask = eight ? 8'hFF : 8'h7F;

    // Next-state logic; TX, TXRDY and tx_done are computed one cycle ahead so the outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        baud_d    = baud_q;
        eight_d   = eight_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        rdy_d     = rdy_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (load && rdy_q) begin
                    // Masking bit 7 in 7-bit mode keeps it out of both the line and the parity.
                    data_d    = out_port & data_mask;
                    baud_d    = baud;
                    eight_d   = eight;
                    par_en_d  = parity;
                    par_bit_d = (^(out_port & data_mask)) ^ OHEL;
                    cnt_d     = '0;
                    bit_d     = 3'd0;
                    tx_d      = 1'b0;
                    rdy_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == last_bit) begin
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    rdy_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle line.
                cnt_d   = '0;
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight and parks the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            data_q    <= 8'h00;
            baud_q    <= 4'h0;
            eight_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            baud_q    <= baud_d;
            eight_q   <= eight_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
        end
    end

    assign TX      = tx_q;
    assign TXRDY   = rdy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine against a per-clock waveform reference model.
// Latency: frame waveforms are compared cycle by cycle from the clock edge that accepts the load.
// Backpressure: exercises loads dropped while busy and a load taken in the TXRDY-return cycle.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] baud = 4'hB;
    logic       eight = 1'b1;
    logic       parity = 1'b0;
    logic       OHEL = 1'b0;
    logic       load = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic       TX;
    logic       TXRDY;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle samples packed as {TX, TXRDY, tx_done}.
    logic [2:0] obs[$];
    logic [2:0] expq[$];

    uart_tx_engine #(.CNT_W(19)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud     (baud),
        .eight    (eight),
        .parity   (parity),
        .OHEL     (OHEL),
        .load     (load),
        .out_port (out_port),
        .TX       (TX),
        .TXRDY    (TXRDY),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    function automatic int bit_time(input logic [3:0] b);
        case (b)
            4'h0: return 333333;
            4'h1: return 83333;
            4'h2: return 41667;
            4'h3: return 20833;
            4'h4: return 10417;
            4'h5: return 5208;
            4'h6: return 2604;
            4'h7: return 1736;
            4'h8: return 868;
            4'h9: return 434;
            4'hA: return 217;
            4'hB: return 109;
            4'hC: return 55;
            4'hD: return 28;
            default: return 868;
        endcase
    endfunction

    // Reference frame: list the line bits, hold each for N clocks, then one ready+done cycle.
    task automatic model_frame(input logic [7:0] d, input logic e, input logic p,
                               input logic o, input logic [3:0] b);
        int   n;
        int   nb;
        logic par;
        logic bits[$];
        n   = bit_time(b);
        nb  = e ? 8 : 7;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (p) bits.push_back(o ? ~par : par);
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (n) expq.push_back({bits[i], 1'b0, 1'b0});
        expq.push_back(3'b111);
    endtask

    task automatic model_idle(input int n);
        repeat (n) expq.push_back(3'b110);
    endtask

    task automatic capture(input int n);
        repeat (n) begin
            obs.push_back({TX, TXRDY, tx_done});
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge (cycle 0 of the frame).
    task automatic start_load(input logic [7:0] d, input logic [3:0] b, input logic e,
                              input logic p, input logic o);
        out_port = d;
        baud     = b;
        eight    = e;
        parity   = p;
        OHEL     = o;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    function automatic int first_diff();
        for (int i = 0; i < expq.size(); i++) begin
            if (i >= obs.size() || obs[i] !== expq[i]) return i;
        end
        return -1;
    endfunction

    function automatic int count_busy();
        int c = 0;
        foreach (obs[i]) if (obs[i][1] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_done();
        int c = 0;
        foreach (obs[i]) if (obs[i][0] == 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        int bad;
        bad = 0;
        #2 reset = 1'b0;
        out_port = 8'hFF;
        repeat (20) begin
            @(negedge clk);
            if ({TX, TXRDY, tx_done} !== 3'b110) bad++;
            load = ~load;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_hold: %0d cycles not idle, required 0", bad);
        end
        load  = 1'b0;
        reset = 1'b1;
        bad   = 0;
        repeat (5) begin
            @(negedge clk);
            if ({TX, TXRDY, tx_done} !== 3'b110) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_release: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_8n1();
        int d;
        obs.delete(); expq.delete();
        start_load(8'h41, 4'hB, 1'b1, 1'b0, 1'b0);
        model_frame(8'h41, 1'b1, 1'b0, 1'b0, 4'hB);
        model_idle(5);
        capture(expq.size());
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL 8n1_wave: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
        n_checks++;
        if (count_busy() != 1090) begin
            n_fail++;
            $display("FAIL 8n1_busy_len: got %0d required 1090", count_busy());
        end
        n_checks++;
        if (count_done() != 1) begin
            n_fail++;
            $display("FAIL 8n1_done_pulses: got %0d required 1", count_done());
        end
    endtask

    task automatic test_parity();
        int d;
        for (int o = 0; o < 2; o++) begin
            obs.delete(); expq.delete();
            start_load(8'h41, 4'hB, 1'b1, 1'b1, o[0]);
            model_frame(8'h41, 1'b1, 1'b1, o[0], 4'hB);
            model_idle(5);
            capture(expq.size());
            d = first_diff();
            n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL parity_wave ohel=%0d: cycle %0d got %b required %b", o, d, obs[d], expq[d]);
            end
            n_checks++;
            if (obs[9*109+50][2] !== o[0]) begin
                n_fail++;
                $display("FAIL parity_bit ohel=%0d: got %b required %b", o, obs[9*109+50][2], o[0]);
            end
            n_checks++;
            if (count_busy() != 1199) begin
                n_fail++;
                $display("FAIL parity_len ohel=%0d: got %0d required 1199", o, count_busy());
            end
        end
    endtask

    task automatic test_7bit();
        int d;
        int ones;
        obs.delete(); expq.delete();
        start_load(8'hFF, 4'hB, 1'b0, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b0, 1'b1, 1'b0, 4'hB);
        model_idle(5);
        capture(expq.size());
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL 7bit_wave: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
        ones = 0;
        for (int b = 1; b <= 9; b++) if (obs[b*109+54][2] === 1'b1) ones++;
        n_checks++;
        if (ones != 9 || count_busy() != 1090) begin
            n_fail++;
            $display("FAIL 7bit_frame: high bits %0d busy %0d required 9 and 1090", ones, count_busy());
        end
    endtask

    task automatic test_busy_load();
        int d;
        obs.delete(); expq.delete();
        start_load(8'h55, 4'hB, 1'b1, 1'b0, 1'b0);
        model_frame(8'h55, 1'b1, 1'b0, 1'b0, 4'hB);
        model_idle(20);
        fork
            capture(expq.size());
            begin
                repeat (300) @(negedge clk);
                out_port = 8'hAA;
                load     = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
        join
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL busy_load_ignored: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        obs.delete(); expq.delete();
        start_load(8'h55, 4'hB, 1'b1, 1'b0, 1'b0);
        model_frame(8'h55, 1'b1, 1'b0, 1'b0, 4'hB);
        model_frame(8'hAA, 1'b1, 1'b0, 1'b0, 4'hB);
        model_idle(5);
        fork
            capture(expq.size());
            begin
                repeat (1090) @(negedge clk);
                out_port = 8'hAA;
                load     = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
        join
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL back_to_back_wave: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
        n_checks++;
        if (count_done() != 2) begin
            n_fail++;
            $display("FAIL back_to_back_done: got %0d required 2", count_done());
        end
    endtask

    task automatic test_config_change();
        int         d;
        logic [7:0] dat;
        dat = 8'($urandom);
        obs.delete(); expq.delete();
        start_load(dat, 4'hB, 1'b1, 1'b1, 1'b0);
        model_frame(dat, 1'b1, 1'b1, 1'b0, 4'hB);
        model_idle(5);
        fork
            capture(expq.size());
            begin
                repeat (200) @(negedge clk);
                baud     = 4'h8;
                eight    = 1'b0;
                parity   = 1'b0;
                OHEL     = 1'b1;
                out_port = ~dat;
            end
        join
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL config_change: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
    endtask

    task automatic test_baud_e();
        int         d;
        logic [7:0] dat;
        dat = 8'($urandom);
        obs.delete(); expq.delete();
        start_load(dat, 4'hE, 1'b1, 1'b0, 1'b0);
        model_frame(dat, 1'b1, 1'b0, 1'b0, 4'h8);
        model_idle(3);
        capture(expq.size());
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL baud_e_wave: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
        n_checks++;
        if (count_busy() != 8680) begin
            n_fail++;
            $display("FAIL baud_e_len: got %0d required 8680", count_busy());
        end
    endtask

    task automatic test_random();
        int         d;
        logic [7:0] dat;
        logic [3:0] b;
        logic       e, p, o;
        for (int t = 0; t < 6; t++) begin
            dat = 8'($urandom);
            b   = 4'(10 + $urandom_range(0, 3));
            e   = 1'($urandom_range(0, 1));
            p   = 1'($urandom_range(0, 1));
            o   = 1'($urandom_range(0, 1));
            obs.delete(); expq.delete();
            start_load(dat, b, e, p, o);
            model_frame(dat, e, p, o, b);
            model_idle(3);
            capture(expq.size());
            d = first_diff();
            n_checks++;
            if (d != -1) begin
                n_fail++;
                $display("FAIL random_frame %0d (d=%h b=%h e=%b p=%b o=%b): cycle %0d got %b required %b",
                         t, dat, b, e, p, o, d, obs[d], expq[d]);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int d;
        obs.delete(); expq.delete();
        start_load(8'h00, 4'hB, 1'b1, 1'b0, 1'b0);
        repeat (3*109) @(negedge clk);
        n_checks++;
        if (TX !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pre: TX got %b required 0", TX);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({TX, TXRDY, tx_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL midreset_async: {TX,TXRDY,tx_done} got %b required 110", {TX, TXRDY, tx_done});
        end
        @(negedge clk);
        reset = 1'b1;
        model_idle(1500);
        capture(expq.size());
        d = first_diff();
        n_checks++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL midreset_residual: cycle %0d got %b required %b", d, obs[d], expq[d]);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7bit();
        test_busy_load();
        test_back_to_back();
        test_config_change();
        test_baud_e();
        test_random();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
